// File: rtl/io_port_responder.sv
// rtl/io_port_responder.sv - CPU I/O bus endpoint with TX/RX byte FIFOs (optional status read: IO_STATUS_EN)

module io_port_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module io_port_responder #(
   parameter logic [7:0] DEV_ADDR = 8'h0F,
   parameter int         TX_DEPTH = 4,
   parameter int         RX_DEPTH = 4
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       IO_clk_e,
   input  logic       IO_clk_s,
   input  logic       IO_input_or_output,
   input  logic       IO_data_or_address,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       selected,
   output logic       tx_overrun,
   output logic       rx_underrun
);
   logic       s_q;
   logic       e_q;
   logic       s_evt;
   logic       e_fall;
   logic       addr_wr;
   logic       data_wr;
   logic       rd_cycle;
   logic       rd_act;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_pop;
   logic       rx_full;
   logic       rx_empty;
   logic       rx_pop;
   logic [7:0] rx_head;

   assign s_evt    = IO_clk_s & ~s_q;
   assign e_fall   = ~IO_clk_e & e_q;
   assign addr_wr  = s_evt & IO_input_or_output & IO_data_or_address;
   assign data_wr  = s_evt & IO_input_or_output & ~IO_data_or_address & selected;
   assign rd_cycle = IO_clk_e & ~IO_input_or_output & ~IO_data_or_address & selected;

   assign tx_valid = ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_ready = ~rx_full;
   // rd_act holds the previous cycle's qualified read, so the pop lands on the strobe's falling edge.
   assign rx_pop   = e_fall & rd_act;

   io_port_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (sys_clk),
      .rst_n (reset),
      .push  (data_wr),
      .pop   (tx_pop),
      .din   (bus_in),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty)
   );

   io_port_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (sys_clk),
      .rst_n (reset),
      .push  (rx_valid & rx_ready),
      .pop   (rx_pop),
      .din   (rx_data),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

`ifdef IO_STATUS_EN
   logic       st_cycle;
   logic       st_act;
   logic       flag_clr;
   logic [7:0] status;

   assign st_cycle = IO_clk_e & ~IO_input_or_output & IO_data_or_address & selected;
   assign flag_clr = e_fall & st_act;
   assign status   = {tx_overrun, rx_underrun, 2'b00, rx_full, rx_empty, tx_full, tx_empty};

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) st_act <= 1'b0;
      else        st_act <= st_cycle;
   end
`else
   logic flag_clr;
   assign flag_clr = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         s_q         <= 1'b1;
         e_q         <= 1'b1;
         rd_act      <= 1'b0;
         selected    <= 1'b0;
         tx_overrun  <= 1'b0;
         rx_underrun <= 1'b0;
      end else begin
         s_q    <= IO_clk_s;
         e_q    <= IO_clk_e;
         rd_act <= rd_cycle;
         if (addr_wr) selected <= (bus_in == DEV_ADDR);
         // A new error in the same cycle as a status clear wins, so it is never lost.
         if (data_wr && tx_full && !tx_pop) tx_overrun <= 1'b1;
         else if (flag_clr)                 tx_overrun <= 1'b0;
         if (rx_pop && rx_empty)            rx_underrun <= 1'b1;
         else if (flag_clr)                 rx_underrun <= 1'b0;
      end
   end

   always_comb begin
      bus_out = 8'h00;
      bus_oe  = 1'b0;
      if (rd_cycle) begin
         bus_oe  = 1'b1;
         bus_out = rx_empty ? 8'h00 : rx_head;
      end
`ifdef IO_STATUS_EN
      else if (st_cycle) begin
         bus_oe  = 1'b1;
         bus_out = status;
      end
`endif
   end
endmodule

// File: tb/tb_io_port_responder.sv
// tb/tb_io_port_responder.sv - directed self-checking bench for io_port_responder

`timescale 1ns/1ps

module tb_io_port_responder;
   logic       sys_clk = 1'b0;
   logic       reset;
   logic       IO_clk_e;
   logic       IO_clk_s;
   logic       IO_input_or_output;
   logic       IO_data_or_address;
   logic [7:0] bus_in;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       selected;
   logic       tx_overrun;
   logic       rx_underrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] rd_val;
   logic       rd_oe;

   always #5 sys_clk = ~sys_clk;

   io_port_responder dut (
      .sys_clk            (sys_clk),
      .reset              (reset),
      .IO_clk_e           (IO_clk_e),
      .IO_clk_s           (IO_clk_s),
      .IO_input_or_output (IO_input_or_output),
      .IO_data_or_address (IO_data_or_address),
      .bus_in             (bus_in),
      .bus_out            (bus_out),
      .bus_oe             (bus_oe),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .rx_data            (rx_data),
      .rx_valid           (rx_valid),
      .rx_ready           (rx_ready),
      .selected           (selected),
      .tx_overrun         (tx_overrun),
      .rx_underrun        (rx_underrun)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic bus_write(input logic is_addr, input logic [7:0] val);
      IO_input_or_output = 1'b1;
      IO_data_or_address = is_addr;
      bus_in             = val;
      IO_clk_s           = 1'b1;
      tick(2);
      IO_clk_s = 1'b0;
      tick(1);
   endtask

   task automatic bus_read(input logic is_addr, output logic [7:0] val, output logic oe);
      IO_input_or_output = 1'b0;
      IO_data_or_address = is_addr;
      IO_clk_e           = 1'b1;
      tick(1);
      val      = bus_out;
      oe       = bus_oe;
      IO_clk_e = 1'b0;
      #1;
      check("oe_drop", {7'd0, bus_oe}, 8'h00);
      tick(2);
   endtask

   initial begin
      reset = 1'b0; IO_clk_e = 1'b0; IO_clk_s = 1'b0;
      IO_input_or_output = 1'b0; IO_data_or_address = 1'b0; bus_in = 8'h00;
      tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      tick(2);
      check("rst_sel",   {7'd0, selected},    8'h00);
      check("rst_txv",   {7'd0, tx_valid},    8'h00);
      check("rst_oe",    {7'd0, bus_oe},      8'h00);
      check("rst_bus",   bus_out,             8'h00);
      check("rst_ovr",   {7'd0, tx_overrun},  8'h00);
      check("rst_und",   {7'd0, rx_underrun}, 8'h00);
      check("rst_rxrdy", {7'd0, rx_ready},    8'h01);
      reset = 1'b1;
      tick(2);

      // 1: address decode
      bus_write(1'b1, 8'h0F);
      check("t1_sel", {7'd0, selected}, 8'h01);
      bus_write(1'b1, 8'h03);
      check("t1_desel", {7'd0, selected}, 8'h00);
      bus_write(1'b0, 8'h77);
      check("t1_ignore", {7'd0, tx_valid}, 8'h00);

      // 2: OUT bytes then drain
      bus_write(1'b1, 8'h0F);
      bus_write(1'b0, 8'hA5);
      bus_write(1'b0, 8'h3C);
      check("t2_txv", {7'd0, tx_valid}, 8'h01);
      check("t2_head", tx_data, 8'hA5);
      tx_ready = 1'b1;
      tick(1);
      check("t2_second", tx_data, 8'h3C);
      check("t2_txv2", {7'd0, tx_valid}, 8'h01);
      tick(1);
      check("t2_empty", {7'd0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

      // 3: TX overrun
      for (int i = 1; i <= 5; i++) bus_write(1'b0, 8'(i));
      check("t3_ovr", {7'd0, tx_overrun}, 8'h01);
      tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t3_drain%0d", i), tx_data, 8'(i));
         tick(1);
      end
      check("t3_empty", {7'd0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

      // 5: status read (tx_overrun set, both FIFOs empty)
`ifdef IO_STATUS_EN
      bus_read(1'b1, rd_val, rd_oe);
      check("t5_oe", {7'd0, rd_oe}, 8'h01);
      check("t5_stat1", rd_val, 8'h85);
      bus_read(1'b1, rd_val, rd_oe);
      check("t5_stat2", rd_val, 8'h05);
      check("t5_ovr_clr", {7'd0, tx_overrun}, 8'h00);
`else
      bus_read(1'b1, rd_val, rd_oe);
      check("t5_no_oe", {7'd0, rd_oe}, 8'h00);
      check("t5_ovr_kept", {7'd0, tx_overrun}, 8'h01);
`endif

      // 4: RX reads and underrun
      rx_valid = 1'b1; rx_data = 8'h11;
      tick(1);
      rx_data = 8'h22;
      tick(1);
      rx_valid = 1'b0;
      bus_read(1'b0, rd_val, rd_oe);
      check("t4_oe1", {7'd0, rd_oe}, 8'h01);
      check("t4_rd1", rd_val, 8'h11);
      bus_read(1'b0, rd_val, rd_oe);
      check("t4_rd2", rd_val, 8'h22);
      check("t4_und0", {7'd0, rx_underrun}, 8'h00);
      bus_read(1'b0, rd_val, rd_oe);
      check("t4_oe3", {7'd0, rd_oe}, 8'h01);
      check("t4_rd3", rd_val, 8'h00);
      check("t4_und1", {7'd0, rx_underrun}, 8'h01);

      // RX full: fifth byte refused
      rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rx_data = 8'h40 + 8'(i);
         tick(1);
      end
      rx_valid = 1'b0;
      check("rx_full_rdy", {7'd0, rx_ready}, 8'h00);
      bus_read(1'b0, rd_val, rd_oe);
      check("rx_full_head", rd_val, 8'h40);
      check("rx_rdy_back", {7'd0, rx_ready}, 8'h01);

      // 6: reset with strobe high and TX holding data
      bus_write(1'b0, 8'hB1);
      bus_write(1'b0, 8'hB2);
      check("t6_txv", {7'd0, tx_valid}, 8'h01);
      IO_input_or_output = 1'b1; IO_data_or_address = 1'b0; bus_in = 8'hEE;
      IO_clk_s = 1'b1;
      reset    = 1'b0;
      #1;
      check("t6_rst_txv", {7'd0, tx_valid}, 8'h00);
      check("t6_rst_sel", {7'd0, selected}, 8'h00);
      check("t6_rst_und", {7'd0, rx_underrun}, 8'h00);
      tick(2);
      reset = 1'b1;
      tick(3);
      check("t6_nopush", {7'd0, tx_valid}, 8'h00);
      IO_clk_s = 1'b0;
      tick(1);

      // Full TX with same-cycle pop: push accepted, no overrun
      bus_write(1'b1, 8'h0F);
      for (int i = 1; i <= 4; i++) bus_write(1'b0, 8'h60 + 8'(i));
      IO_data_or_address = 1'b0; bus_in = 8'h99;
      IO_clk_s = 1'b1; tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      tick(1);
      IO_clk_s = 1'b0;
      tick(1);
      check("fp_no_ovr", {7'd0, tx_overrun}, 8'h00);
      tx_ready = 1'b1;
      check("fp_d2", tx_data, 8'h62); tick(1);
      check("fp_d3", tx_data, 8'h63); tick(1);
      check("fp_d4", tx_data, 8'h64); tick(1);
      check("fp_d5", tx_data, 8'h99); tick(1);
      check("fp_empty", {7'd0, tx_valid}, 8'h00);
      tx_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
